// File: rtl/vector_hazard_unit.sv
// Hazard unit for the vector pipeline: tracks destination tags through E/M/W,
// selects Execute operand forwarding and generates stall/flush controls.
module vector_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  WA3D,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        ValidD,
  input  logic        BranchTakenE,
  input  logic        MemBusyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [15:0] StallCount
);

  logic [3:0]  ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic        regwrite_e, memtoreg_e, valid_e;
  logic        regwrite_m, valid_m;
  logic        regwrite_w, valid_w;
  logic [15:0] stall_count;

  logic src_m, src_w;
  logic load_use;
  logic busy_act, branch_act, lu_act;

  assign src_m = valid_m & regwrite_m;
  assign src_w = valid_w & regwrite_w;

  // M has priority over W so the youngest producer wins
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (valid_e) begin
      if (src_m && (ra1_e == wa3_m))      ForwardAE = 2'b10;
      else if (src_w && (ra1_e == wa3_w)) ForwardAE = 2'b01;
      if (src_m && (ra2_e == wa3_m))      ForwardBE = 2'b10;
      else if (src_w && (ra2_e == wa3_w)) ForwardBE = 2'b01;
    end
  end

  assign load_use = valid_e & regwrite_e & memtoreg_e & ValidD &
                    ((wa3_e == RA1D) | (wa3_e == RA2D));

  // rst_n gating keeps the controls quiet even if the raw inputs are active in reset
  assign busy_act   = rst_n & MemBusyM;
  assign branch_act = rst_n & ~MemBusyM & BranchTakenE;
  assign lu_act     = rst_n & ~MemBusyM & ~BranchTakenE & load_use;

  assign StallF     = busy_act | lu_act;
  assign StallD     = busy_act | lu_act;
  assign StallE     = busy_act;
  assign StallM     = busy_act;
  assign FlushD     = branch_act;
  assign FlushE     = branch_act | lu_act;
  assign StallCount = stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra1_e       <= 4'd0;
      ra2_e       <= 4'd0;
      wa3_e       <= 4'd0;
      regwrite_e  <= 1'b0;
      memtoreg_e  <= 1'b0;
      valid_e     <= 1'b0;
      wa3_m       <= 4'd0;
      regwrite_m  <= 1'b0;
      valid_m     <= 1'b0;
      wa3_w       <= 4'd0;
      regwrite_w  <= 1'b0;
      valid_w     <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (busy_act) begin
        // E and M freeze; W drains to a bubble
        wa3_w      <= 4'd0;
        regwrite_w <= 1'b0;
        valid_w    <= 1'b0;
      end else begin
        wa3_w      <= wa3_m;
        regwrite_w <= regwrite_m;
        valid_w    <= valid_m;
        wa3_m      <= wa3_e;
        regwrite_m <= regwrite_e;
        valid_m    <= valid_e;
        if (branch_act || lu_act) begin
          ra1_e      <= 4'd0;
          ra2_e      <= 4'd0;
          wa3_e      <= 4'd0;
          regwrite_e <= 1'b0;
          memtoreg_e <= 1'b0;
          valid_e    <= 1'b0;
        end else begin
          ra1_e      <= RA1D;
          ra2_e      <= RA2D;
          wa3_e      <= WA3D;
          regwrite_e <= RegWriteD;
          memtoreg_e <= MemtoRegD;
          valid_e    <= ValidD;
        end
      end
      if (StallF && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vector_hazard_unit.sv
// Bench for vector_hazard_unit: directed hazard scenarios plus random traffic
// compared against an instruction-level pipeline model.
module tb_vector_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, ValidD, BranchTakenE, MemBusyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [15:0] StallCount;

  always #5 clk = ~clk;

  vector_hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .ValidD(ValidD),
    .BranchTakenE(BranchTakenE), .MemBusyM(MemBusyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .StallCount(StallCount)
  );

  typedef struct packed {
    logic       v, rw, mr;
    logic [3:0] ra1, ra2, wa;
  } instr_t;

  instr_t e, m, w;
  int     sc;
  int     total = 0, bad = 0;

  logic [1:0]  obs_fa, obs_fb, obs_fl;
  logic [3:0]  obs_st;
  logic [15:0] obs_sc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // operand source: nearest older in-flight writer of the register, if any
  function automatic logic [1:0] src_of(input logic [3:0] ra);
    if (!e.v) return 2'b00;
    if (m.v && m.rw && m.wa == ra) return 2'b10;
    if (w.v && w.rw && w.wa == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    e = '0; m = '0; w = '0; sc = 0;
  endtask

  task automatic cyc(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                     input logic rw, input logic mr, input logic v,
                     input logic br, input logic busy);
    bit     xb, xbr, xlu;
    instr_t d;
    RA1D = a1; RA2D = a2; WA3D = wa; RegWriteD = rw; MemtoRegD = mr;
    ValidD = v; BranchTakenE = br; MemBusyM = busy;
    d.v = v; d.rw = rw; d.mr = mr; d.ra1 = a1; d.ra2 = a2; d.wa = wa;
    #4;
    xb  = busy;
    xbr = !busy && br;
    xlu = !busy && !br && e.v && e.rw && e.mr && v && (e.wa == a1 || e.wa == a2);
    obs_fa = ForwardAE; obs_fb = ForwardBE;
    obs_st = {StallF, StallD, StallE, StallM};
    obs_fl = {FlushD, FlushE};
    obs_sc = StallCount;
    check("fwdA", obs_fa, src_of(e.ra1));
    check("fwdB", obs_fb, src_of(e.ra2));
    check("stall", obs_st, {xb | xlu, xb | xlu, xb, xb});
    check("flush", obs_fl, {xbr, xbr | xlu});
    check("count", obs_sc, sc);
    @(posedge clk);
    if (xb) begin
      w = '0;
    end else begin
      w = m;
      m = e;
      e = (xbr || xlu) ? instr_t'(0) : d;
    end
    if ((xb || xlu) && sc < 65535) sc++;
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa);
    cyc(a1, a2, wa, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int sc0;
    rst_n = 1'b0;
    RA1D = 4'd7; RA2D = 4'd7; WA3D = 4'd7; RegWriteD = 1'b1; MemtoRegD = 1'b1;
    ValidD = 1'b1; BranchTakenE = 1'b1; MemBusyM = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    check("rst_stall", {StallF, StallD, StallE, StallM}, 4'b0000);
    check("rst_flush", {FlushD, FlushE}, 2'b00);
    check("rst_count", StallCount, 16'd0);
    rst_n = 1'b1;

    // ALU producer then consumer on RA1
    alu(4'd0, 4'd0, 4'd3);
    alu(4'd3, 4'd1, 4'd4);
    nop(1);
    check("r021_fa", obs_fa, 2'b10);
    check("r021_fb", obs_fb, 2'b00);

    // back-to-back writers of v5, M beats W
    nop(3);
    alu(4'd0, 4'd0, 4'd5);
    alu(4'd0, 4'd0, 4'd5);
    alu(4'd0, 4'd5, 4'd6);
    nop(1);
    check("r022_m", obs_fb, 2'b10);
    nop(3);
    alu(4'd0, 4'd0, 4'd5);
    alu(4'd1, 4'd2, 4'd9);
    alu(4'd0, 4'd5, 4'd6);
    nop(1);
    check("r022_w", obs_fb, 2'b01);

    // load-use: one bubble, then forward from W
    nop(3);
    sc0 = StallCount;
    cyc(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    alu(4'd7, 4'd2, 4'd8);
    check("r023_stall", {obs_st[3], obs_st[2], obs_fl[0]}, 3'b111);
    alu(4'd7, 4'd2, 4'd8);
    check("r023_nostall", obs_st, 4'b0000);
    nop(1);
    check("r023_fa", obs_fa, 2'b01);
    check("r023_cnt", obs_sc, sc0 + 1);

    // branch suppresses load-use
    nop(3);
    sc0 = StallCount;
    cyc(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'd7, 4'd2, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("r024_flush", obs_fl, 2'b11);
    check("r024_stallf", obs_st[3], 1'b0);
    nop(1);
    check("r024_cnt", obs_sc, sc0);

    // memory busy holds a forwarding consumer, load-use waits for release
    nop(3);
    sc0 = StallCount;
    alu(4'd0, 4'd0, 4'd3);
    cyc(4'd3, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd7, 4'd1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      check("r025_fa", obs_fa, 2'b10);
      check("r025_st", obs_st, 4'b1111);
      check("r025_fl", obs_fl, 2'b00);
    end
    alu(4'd7, 4'd1, 4'd8);
    check("r025_lu", {obs_st, obs_fl}, 6'b110001);
    alu(4'd7, 4'd1, 4'd8);
    check("r025_done", obs_st, 4'b0000);
    check("r025_cnt", obs_sc, sc0 + 4);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 7) == 0));

    // saturation: fill with busy stalls
    while (sc < 65534) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r026_pre", StallCount, 16'hFFFE);
    repeat (3) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("r026_sat", StallCount, 16'hFFFF);

    // reset pulse in the middle of a stall
    MemBusyM = 1'b1; BranchTakenE = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("r026_rfwd", {ForwardAE, ForwardBE}, 4'b0000);
    check("r026_rstall", {StallF, StallD, StallE, StallM}, 4'b0000);
    check("r026_rflush", {FlushD, FlushE}, 2'b00);
    check("r026_rcnt", StallCount, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // post-reset: first edge loads D normally
    alu(4'd0, 4'd0, 4'd2);
    alu(4'd2, 4'd2, 4'd3);
    nop(1);
    check("r020_fwd", {obs_fa, obs_fb}, 4'b1010);
    for (int i = 0; i < 200; i++)
      cyc(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 5) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_hazard_unit.md
VECTOR_HAZARD_UNIT -- requirements
Module: vector_hazard_unit

Interface
REQ-001 The module SHALL have exactly one clock port, clk, and exactly one reset port, rst_n; rst_n SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- RA1D, RA2D  in  4 each  decode-stage vector source register indices
- WA3D  in  4  decode-stage destination register index
- RegWriteD  in  1  decode instruction writes the register file
- MemtoRegD  in  1  decode instruction is a vector load
- ValidD  in  1  decode slot holds a real instruction
- BranchTakenE  in  1  branch in Execute resolved taken
- MemBusyM  in  1  vector memory access in Memory not finished
- ForwardAE, ForwardBE  out  2 each  Execute operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1 each  hold the named pipeline register
- FlushD, FlushE  out  1 each  clear the named pipeline register to a bubble
- StallCount  out  16  saturating count of stalled cycles

Function
REQ-003 The unit SHALL keep an internal tag pipeline: E stage (RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, ValidE), M stage (WA3M, RegWriteM, ValidM), and W stage (WA3W, RegWriteW, ValidW).
REQ-004 The tag pipeline SHALL advance on each rising clk edge: D fields to E, E to M, M to W, subject to REQ-010 to REQ-013.
REQ-005 A stage SHALL be a forwarding source only when both its Valid and RegWrite bits are 1.
REQ-006 ForwardAE SHALL be 10 when RA1E equals WA3M and M is a source.
REQ-007 ForwardAE SHALL otherwise be 01 when RA1E equals WA3W and W is a source, and 00 in all other cases.
REQ-008 ForwardBE SHALL apply the rules of REQ-006 and REQ-007 to RA2E; when both M and W match, M SHALL have priority.
REQ-009 ForwardAE and ForwardBE SHALL be combinational from the registered tags only, and SHALL be 00 whenever ValidE is 0.
REQ-010 Load-use: LoadUse SHALL be asserted when ValidE, RegWriteE, MemtoRegE and ValidD are all 1 and WA3E equals RA1D or RA2D.
- Response: StallF=1, StallD=1, FlushE=1 for that cycle.
- The E tags SHALL become a bubble (all Valid/RegWrite bits 0) while the D fields are re-presented.
- Since a load never forwards from M, the stall SHALL last exactly 1 cycle.
REQ-011 Branch: when BranchTakenE=1, FlushD=1 and FlushE=1; the E tags SHALL load a bubble and the M tags SHALL take the old E tags.
REQ-012 Memory busy: when MemBusyM=1, StallF, StallD, StallE and StallM SHALL all be 1 and FlushD=FlushE=0.
- F, D, E and M tags SHALL hold; W tags SHALL load a bubble.
- Forward outputs SHALL be recomputed from the held E tags.
REQ-013 Priority SHALL be MemBusyM > BranchTakenE > LoadUse.
- Under MemBusyM, BranchTakenE and LoadUse SHALL be ignored that cycle and re-evaluated afterwards.
- Under BranchTakenE, LoadUse SHALL be suppressed.
REQ-014 StallCount SHALL increment by 1 on each edge where StallF=1, and SHALL saturate at 0xFFFF.
REQ-015 All stall and flush outputs SHALL be combinational from the current inputs and registered tags, with no added latency.
REQ-016 ValidD=0 SHALL never cause a stall.

Reset
REQ-017 While rst_n=0, all Valid, RegWrite and MemtoReg tag bits SHALL be 0, all register-index tags SHALL be 0, and StallCount SHALL be 0.
REQ-018 While rst_n=0, the outputs SHALL be: Forward 00, all Stall 0, all Flush 0.
REQ-019 An assertion of rst_n mid-stall SHALL abandon the stall immediately with no residual state.
REQ-020 After rst_n rises, the first edge SHALL load D fields normally.

Verification
REQ-021 ALU writes v3, next instruction reads v3 as RA1 -> in the reader's E cycle ForwardAE=10, ForwardBE=00.
REQ-022 Writers of v5 in two consecutive instructions, then a reader of v5 as RA2 -> ForwardBE=10 (M wins over W); with one unrelated instruction between writer and reader -> ForwardBE=01.
REQ-023 Load v7 followed by an add reading v7 -> for 1 cycle StallF=StallD=FlushE=1; next cycle ForwardAE=01 and no stall; StallCount=1.
REQ-024 LoadUse and BranchTakenE in the same cycle -> FlushD=FlushE=1, StallF=0, StallCount unchanged.
REQ-025 MemBusyM=1 for 3 cycles with an E consumer matching WA3M -> ForwardAE=10 held all 3 cycles, all stalls 1, StallCount +3; LoadUse pending on release resolves in 1 further cycle.
REQ-026 StallCount preloaded to 0xFFFE by forcing stalls, then 3 more stall cycles -> StallCount=0xFFFF; rst_n pulsed low mid-stall -> all outputs at reset values and StallCount=0 asynchronously.
